// File: rtl/recovered_bit_deframer.sv
// Packs a 0..2 bit/cycle recovered stream into bytes, hunts for the
// sync word and emits framed payload bytes while locked.
module recovered_bit_deframer #(
  parameter logic [7:0] SYNC_WORD = 8'hD5,
  parameter int         FRAME_LEN = 16,
  parameter int         MISS_MAX  = 3
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [1:0] bit_data,
  input  logic [1:0] bit_cnt,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic       cnt_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [7:0] LAST = 8'(FRAME_LEN);
  localparam logic [2:0] MMAX = 3'(MISS_MAX);

  state_t     state, state_n;
  logic [7:0] win, win_n;
  logic [3:0] fill, fill_n;
  logic [2:0] pos, pos_n;
  logic [7:0] idx, idx_n;
  logic [2:0] miss, miss_n;
  logic       bv_n, fs_n, se_n;
  logic [7:0] bo_n;
  logic [1:0] nb;
  logic       b, use_bit;

  // Walk the (up to two) bits of this cycle in arrival order
  always_comb begin
    state_n = state;
    win_n   = win;
    fill_n  = fill;
    pos_n   = pos;
    idx_n   = idx;
    miss_n  = miss;
    bv_n    = 1'b0;
    fs_n    = 1'b0;
    se_n    = 1'b0;
    bo_n    = byte_out;
    b       = 1'b0;
    use_bit = 1'b0;
    nb      = (bit_cnt == 2'd3) ? 2'd0 : bit_cnt;
    for (int k = 0; k < 2; k++) begin
      use_bit = (k == 0) ? (nb != 2'd0) : (nb == 2'd2);
      b       = (k == 0) ? bit_data[0] : bit_data[1];
      if (use_bit) begin
        win_n = {win_n[6:0], b};
        if (state_n == HUNT) begin
          if (fill_n != 4'd8)
            fill_n = fill_n + 4'd1;
          if (fill_n == 4'd8 && win_n == SYNC_WORD) begin
            state_n = LOCKED;
            pos_n   = 3'd0;
            idx_n   = 8'd0;
            miss_n  = 3'd0;
          end
        end else if (pos_n != 3'd7) begin
          pos_n = pos_n + 3'd1;
        end else begin
          pos_n = 3'd0;
          if (idx_n == LAST) begin
            idx_n = 8'd0;
            if (win_n == SYNC_WORD) begin
              miss_n = 3'd0;
            end else begin
              se_n   = 1'b1;
              miss_n = miss_n + 3'd1;
              if (miss_n == MMAX) begin
                state_n = HUNT;
                win_n   = 8'd0;
                fill_n  = 4'd0;
              end
            end
          end else begin
            bv_n  = 1'b1;
            bo_n  = win_n;
            fs_n  = (idx_n == 8'd0);
            idx_n = idx_n + 8'd1;
          end
        end
      end
    end
  end

  // Framing state and registered outputs
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= HUNT;
      win         <= 8'd0;
      fill        <= 4'd0;
      pos         <= 3'd0;
      idx         <= 8'd0;
      miss        <= 3'd0;
      byte_out    <= 8'd0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      cnt_err     <= 1'b0;
    end else begin
      state       <= state_n;
      win         <= win_n;
      fill        <= fill_n;
      pos         <= pos_n;
      idx         <= idx_n;
      miss        <= miss_n;
      byte_out    <= bo_n;
      byte_valid  <= bv_n;
      frame_start <= fs_n;
      locked      <= (state_n == LOCKED);
      sync_err    <= se_n;
      cnt_err     <= (bit_cnt == 2'd3);
    end
  end

endmodule
